// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - datapath-to-byte-RAM access stage with big-endian split and load extension
//
// Splits byte/halfword/word requests into serial byte accesses on a byte-wide
// synchronous RAM. Stores are sent MSB first at the base address. Loads are
// assembled MSB first and then zero- or sign-extended.
//
// Ports
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   MOV, RW, MS           request strobe (level, held until MOC), 1=read, size/sign
//   ADDR, DATA_IN         byte address (low ADDR_W bits used), store data
//   DATA_OUT              registered load result
//   MOC, ERR              operation complete, misaligned/reserved-size flag
//   BYTE_ADDR/WDATA/WE/RE RAM byte access, one byte per cycle
//   BYTE_RDATA            RAM read byte, valid the cycle after BYTE_RE
module mem_access_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              MOV,
    input  logic              RW,
    input  logic [2:0]        MS,
    input  logic [31:0]       ADDR,
    input  logic [31:0]       DATA_IN,
    output logic [31:0]       DATA_OUT,
    output logic              MOC,
    output logic              ERR,
    output logic [ADDR_W-1:0] BYTE_ADDR,
    output logic [7:0]        BYTE_WDATA,
    output logic              BYTE_WE,
    output logic              BYTE_RE,
    input  logic [7:0]        BYTE_RDATA
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        RLAST = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t            state, state_n;
    logic              rw_q;
    logic              sext_q;
    logic [1:0]        last_q;     // index of the final byte: N-1
    logic [1:0]        k_q;        // byte index within the transfer
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [23:0]       acc_q;      // earlier read bytes, most recent in the low byte
    logic              err_q;
    logic [31:0]       dout_q;

    logic              bad;
    logic [1:0]        last_d;
    logic [1:0]        widx;
    logic [31:0]       wshift;
    logic [31:0]       full;
    logic [31:0]       ext;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^ADDR[31:ADDR_W];

    // Reserved size, or halfword/word not naturally aligned.
    always_comb begin
        bad = 1'b0;
        case (MS[1:0])
            2'b01:   bad = ADDR[0];
            2'b10:   bad = (ADDR[1:0] != 2'b00);
            2'b11:   bad = 1'b1;
            default: bad = 1'b0;
        endcase
    end

    always_comb begin
        case (MS[1:0])
            2'b00:   last_d = 2'd0;
            2'b01:   last_d = 2'd1;
            default: last_d = 2'd3;
        endcase
    end

    // Byte k of the transfer carries byte (N-1-k) of the store data.
    assign widx   = last_q - k_q;
    assign wshift = wdata_q >> {widx, 3'b000};

    // Final read byte arrives in RLAST; combine it with the accumulator.
    assign full = {acc_q, BYTE_RDATA};

    always_comb begin
        case (last_q)
            2'd0:    ext = {{24{sext_q & full[7]}},  full[7:0]};
            2'd1:    ext = {{16{sext_q & full[15]}}, full[15:0]};
            default: ext = full;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        MOC        = 1'b0;
        BYTE_WE    = 1'b0;
        BYTE_RE    = 1'b0;
        BYTE_ADDR  = '0;
        BYTE_WDATA = 8'h00;
        case (state)
            IDLE: begin
                if (MOV) begin
                    state_n = bad ? ACK : XFER;
                end
            end
            XFER: begin
                BYTE_ADDR = base_q + ADDR_W'(k_q);
                if (rw_q) begin
                    BYTE_RE = 1'b1;
                end else begin
                    BYTE_WE    = 1'b1;
                    BYTE_WDATA = wshift[7:0];
                end
                if (k_q == last_q) begin
                    state_n = rw_q ? RLAST : ACK;
                end
            end
            RLAST: begin
                state_n = ACK;
            end
            ACK: begin
                MOC = 1'b1;
                if (!MOV) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rw_q    <= 1'b0;
            sext_q  <= 1'b0;
            last_q  <= 2'd0;
            k_q     <= 2'd0;
            base_q  <= '0;
            wdata_q <= 32'h0;
            acc_q   <= 24'h0;
            err_q   <= 1'b0;
            dout_q  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (MOV) begin
                        rw_q    <= RW;
                        sext_q  <= MS[2];
                        last_q  <= last_d;
                        k_q     <= 2'd0;
                        base_q  <= ADDR[ADDR_W-1:0];
                        wdata_q <= DATA_IN;
                        acc_q   <= 24'h0;
                        err_q   <= bad;
                    end
                end
                XFER: begin
                    k_q <= k_q + 2'd1;
                    // Data for the strobe issued in the previous XFER cycle.
                    if (rw_q && (k_q != 2'd0)) begin
                        acc_q <= {acc_q[15:0], BYTE_RDATA};
                    end
                end
                RLAST: begin
                    dout_q <= ext;
                end
                ACK: begin
                    if (!MOV) begin
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ERR      = err_q;
    assign DATA_OUT = dout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with behavioural byte-memory model
module tb_mem_access_ctrl;

    localparam int ADDR_W = 8;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              MOV = 1'b0;
    logic              RW = 1'b0;
    logic [2:0]        MS = 3'b000;
    logic [31:0]       ADDR = 32'h0;
    logic [31:0]       DATA_IN = 32'h0;
    logic [31:0]       DATA_OUT;
    logic              MOC;
    logic              ERR;
    logic [ADDR_W-1:0] BYTE_ADDR;
    logic [7:0]        BYTE_WDATA;
    logic              BYTE_WE;
    logic              BYTE_RE;
    logic [7:0]        BYTE_RDATA;

    mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .MOV        (MOV),
        .RW         (RW),
        .MS         (MS),
        .ADDR       (ADDR),
        .DATA_IN    (DATA_IN),
        .DATA_OUT   (DATA_OUT),
        .MOC        (MOC),
        .ERR        (ERR),
        .BYTE_ADDR  (BYTE_ADDR),
        .BYTE_WDATA (BYTE_WDATA),
        .BYTE_WE    (BYTE_WE),
        .BYTE_RE    (BYTE_RE),
        .BYTE_RDATA (BYTE_RDATA)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    function automatic logic [7:0] init_byte(int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Byte-wide synchronous RAM attached to the DUT.
    logic [7:0] ram [256];
    logic [7:0] rdata_q = 8'h00;
    logic       ram_init = 1'b0;
    assign BYTE_RDATA = rdata_q;

    always @(posedge CLK) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_byte(i);
            ram_init <= 1'b1;
        end else begin
            if (BYTE_WE) ram[BYTE_ADDR] <= BYTE_WDATA;
            if (BYTE_RE) rdata_q <= ram[BYTE_ADDR];
        end
    end

    // Reference model state.
    logic [7:0]  ref_mem [256];
    logic [31:0] exp_dout = 32'h0;

    typedef struct {
        logic [31:0] dout;
        logic        err;
        int          lat;
        int          strobes;
        int          issue;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: counts RAM strobes and checks each completion against the scoreboard.
    int   strobe_cnt = 0;
    logic moc_prev = 1'b0;
    always @(negedge CLK) begin
        if (!RST_N) begin
            strobe_cnt = 0;
            moc_prev   = 1'b0;
        end else begin
            if (BYTE_WE && BYTE_RE) check("strobes_exclusive", 32'(BYTE_WE & BYTE_RE), 32'h0);
            if (BYTE_WE || BYTE_RE) strobe_cnt++;
            if (MOC && !moc_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_moc", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("data_out", DATA_OUT, e.dout);
                    check("err", 32'(ERR), 32'(e.err));
                    check("latency", 32'(cyc - e.issue), 32'(e.lat));
                    check("strobe_count", 32'(strobe_cnt), 32'(e.strobes));
                end
                strobe_cnt = 0;
            end
            moc_prev = MOC;
        end
    end

    // Called just after a negedge; returns just after a negedge with MOV low for one cycle.
    task automatic do_req(logic rw, logic [2:0] ms, logic [31:0] addr, logic [31:0] din, int hold);
        int     n;
        logic   bad;
        longint v;
        exp_t   e;
        n   = (ms[1:0] == 2'b00) ? 1 : (ms[1:0] == 2'b01) ? 2 : 4;
        bad = (ms[1:0] == 2'b11) || (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
        if (bad) begin
            e = '{dout: exp_dout, err: 1'b1, lat: 1, strobes: 0, issue: cyc};
        end else if (!rw) begin
            for (int i = 0; i < n; i++)
                ref_mem[(int'(addr[7:0]) + i) & 255] = 8'((din >> (8 * (n - 1 - i))) & 32'hFF);
            e = '{dout: exp_dout, err: 1'b0, lat: n + 1, strobes: n, issue: cyc};
        end else begin
            v = 0;
            for (int i = 0; i < n; i++)
                v = v * 256 + longint'(ref_mem[(int'(addr[7:0]) + i) & 255]);
            if (ms[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                v = v - (longint'(1) << (8 * n));
            exp_dout = 32'(v);
            e = '{dout: exp_dout, err: 1'b0, lat: n + 2, strobes: n, issue: cyc};
        end
        sb.push_back(e);
        MOV = 1'b1; RW = rw; MS = ms; ADDR = addr; DATA_IN = din;
        for (int t = 0; t < 20; t++) begin
            @(negedge CLK);
            if (MOC) break;
            ADDR = $urandom; DATA_IN = $urandom; RW = 1'($urandom); MS = 3'($urandom);
        end
        if (!MOC) check("moc_timeout", 32'(MOC), 32'h1);
        repeat (hold) @(negedge CLK);
        MOV = 1'b0;
        @(negedge CLK);
        check("moc_after_release", 32'(MOC), 32'h0);
        check("err_after_release", 32'(ERR), 32'h0);
    endtask

    task automatic reset_mid_write(logic [31:0] din);
        logic hit;
        hit = 1'b0;
        MOV = 1'b1; RW = 1'b0; MS = 3'b010; ADDR = 32'h40; DATA_IN = din;
        for (int t = 0; t < 20; t++) begin
            @(negedge CLK);
            if (BYTE_WE && BYTE_ADDR == 8'h42) begin
                hit = 1'b1;
                break;
            end
        end
        check("reach_byte2", 32'(hit), 32'h1);
        #1 RST_N = 1'b0;
        #1;
        check("rst_moc", 32'(MOC), 32'h0);
        check("rst_we", 32'(BYTE_WE), 32'h0);
        check("rst_re", 32'(BYTE_RE), 32'h0);
        check("rst_data_out", DATA_OUT, 32'h0);
        ref_mem[8'h40] = din[31:24];
        ref_mem[8'h41] = din[23:16];
        exp_dout = 32'h0;
        MOV = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_data_out", DATA_OUT, 32'h0);
        check("reset_moc", 32'(MOC), 32'h0);
        check("reset_err", 32'(ERR), 32'h0);
        check("reset_strobes", 32'({BYTE_WE, BYTE_RE}), 32'h0);
        check("reset_byte_addr", 32'(BYTE_ADDR), 32'h0);
        RST_N = 1'b1;

        do_req(1'b0, 3'b010, 32'h10, 32'hE09C802C, 0);
        do_req(1'b1, 3'b010, 32'h10, 32'h0, 0);
        check("word_readback", DATA_OUT, 32'hE09C802C);
        do_req(1'b1, 3'b100, 32'h11, 32'h0, 0);
        check("signed_byte", DATA_OUT, 32'hFFFFFF9C);
        do_req(1'b1, 3'b000, 32'h11, 32'h0, 0);
        check("unsigned_byte", DATA_OUT, 32'h0000009C);
        do_req(1'b0, 3'b001, 32'h20, 32'h00001234, 0);
        do_req(1'b1, 3'b101, 32'h20, 32'h0, 0);
        check("signed_half_pos", DATA_OUT, 32'h00001234);
        do_req(1'b0, 3'b001, 32'h20, 32'h00008001, 0);
        do_req(1'b1, 3'b101, 32'h20, 32'h0, 0);
        check("signed_half_neg", DATA_OUT, 32'hFFFF8001);
        do_req(1'b1, 3'b010, 32'h02, 32'h0, 0);
        do_req(1'b1, 3'b011, 32'h10, 32'h0, 0);
        do_req(1'b0, 3'b001, 32'h21, 32'hFFFF, 0);
        do_req(1'b1, 3'b010, 32'h10, 32'h0, 3);
        do_req(1'b1, 3'b000, 32'hFF, 32'h0, 0);

        reset_mid_write(32'hA1B2C3D4);
        do_req(1'b1, 3'b010, 32'h40, 32'h0, 0);

        for (int r = 0; r < 40; r++) begin
            logic [2:0]  ms;
            logic [31:0] a;
            ms[1:0] = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ms[2]   = 1'($urandom);
            a       = {24'h0, 8'($urandom)};
            if ($urandom % 4 != 0) begin
                if (ms[1:0] == 2'b01) a[0] = 1'b0;
                if (ms[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            do_req(1'($urandom), ms, a, $urandom, int'($urandom_range(0, 2)));
        end

        repeat (2) @(negedge CLK);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        for (int i = 0; i < 256; i++) check("ram_contents", 32'(ram[i]), 32'(ref_mem[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
